// File: rtl/round_controller_pkg.sv
// Shared definitions for the Not Not round sequencer: FSM state encodings,
// colour indices and the single-keypress test.
package round_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEXT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DRAW   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_LOST   = 3'd5
    } state_e;

    localparam int unsigned COLOUR_RED    = 0;
    localparam int unsigned COLOUR_GREEN  = 1;
    localparam int unsigned COLOUR_BLUE   = 2;
    localparam int unsigned COLOUR_YELLOW = 3;
    localparam int unsigned NUM_COLOURS   = 4;

    // True when exactly one key bit is set.
    function automatic logic single_bit(input logic [NUM_COLOURS-1:0] key);
        return (key != '0) && ((key & (key - NUM_COLOURS'(1))) == '0);
    endfunction

endpackage

// File: rtl/round_controller_if.sv
// Handshake bundle between the round sequencer and its surroundings
// (keys/switches in, LFSR and text_display controls out).
interface round_controller_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic [3:0]         answer_mask;
    logic [3:0]         player_key;
    logic               done_draw;
    logic               lfsr_enable;
    logic               draw_enable;
    logic               show_start;
    logic               lose;
    logic               round_active;
    logic [3:0]         time_left;
    logic [SCORE_W-1:0] score;

    modport master (
        output start, answer_mask, player_key, done_draw,
        input  lfsr_enable, draw_enable, show_start, lose, round_active, time_left, score
    );

    modport slave (
        input  start, answer_mask, player_key, done_draw,
        output lfsr_enable, draw_enable, show_start, lose, round_active, time_left, score
    );
endinterface

// File: rtl/round_controller_timer.sv
// Answer-window down-counter: loads a start value, counts down to zero and
// holds there, flagging expiry while the count is zero.
module round_controller_timer #(
    parameter int unsigned TICK_W = 28
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_value_i,
    input  logic              dec_i,
    output logic [TICK_W-1:0] count_o,
    output logic              expired_o
);
    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - TICK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == '0);

endmodule

// File: rtl/round_controller.sv
// Not Not game sequencer: start screen, per-round LFSR advance and redraw,
// answer timing, key judging against the colour mask, and scoring.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int unsigned ROUND_TICKS = 150_000_000,
    parameter int unsigned TICK_W      = 28,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic         clock,
    input  logic         resetn,
    round_controller_if.slave bus
);
    state_e             state_q;
    state_e             state_d;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;

    logic               timer_load;
    logic               timer_dec;
    logic [TICK_W-1:0]  timer_count;
    logic               timer_expired;
    logic               round_won;
    logic               key_hits_mask;

    round_controller_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clock        (clock),
        .resetn       (resetn),
        .load_i       (timer_load),
        .load_value_i (TICK_W'(ROUND_TICKS - 1)),
        .dec_i        (timer_dec),
        .count_o      (timer_count),
        .expired_o    (timer_expired)
    );

    assign key_hits_mask = single_bit(bus.player_key) && ((bus.player_key & bus.answer_mask) != 4'd0);

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        round_won  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    score_d = '0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_DRAW;
            ST_DRAW: begin
                if (bus.done_draw) begin
                    timer_load = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                timer_dec = 1'b1;
                // A key press on the expiry cycle is judged as a key press.
                if (bus.player_key != 4'd0) begin
                    if (key_hits_mask) begin
                        round_won = 1'b1;
                    end else begin
                        state_d = ST_LOST;
                    end
                end else if (timer_expired) begin
                    if (bus.answer_mask == 4'd0) begin
                        round_won = 1'b1;
                    end else begin
                        state_d = ST_LOST;
                    end
                end
            end
            ST_LOST: begin
                if (bus.start) begin
                    score_d = '0;
                    state_d = ST_NEXT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (round_won) begin
            state_d = ST_NEXT;
            if (score_q != '1) begin
                score_d = score_q + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
        end
    end

    // Outputs decode the registered state only, so reset clears them at once.
    assign bus.show_start   = (state_q == ST_IDLE);
    assign bus.lfsr_enable  = (state_q == ST_NEXT);
    assign bus.draw_enable  = (state_q == ST_DRAW);
    assign bus.round_active = (state_q == ST_PLAY);
    assign bus.lose         = (state_q == ST_LOST);
    assign bus.time_left    = (state_q == ST_PLAY) ? timer_count[TICK_W-1 -: 4] : 4'd0;
    assign bus.score        = score_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with ROUND_TICKS=20; a second instance
// with a 2-bit score mirrors the stimulus to exercise score saturation.
module tb_round_controller;

    logic clock;
    logic resetn;

    round_controller_if #(.SCORE_W(8)) bus ();
    round_controller_if #(.SCORE_W(2)) bus2 ();

    assign bus2.start       = bus.start;
    assign bus2.answer_mask = bus.answer_mask;
    assign bus2.player_key  = bus.player_key;
    assign bus2.done_draw   = bus.done_draw;

    round_controller #(
        .ROUND_TICKS (20),
        .TICK_W      (5),
        .SCORE_W     (8)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    round_controller #(
        .ROUND_TICKS (20),
        .TICK_W      (5),
        .SCORE_W     (2)
    ) dut_sat (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] key;
        logic       win;
        logic [7:0] score;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From NEXT: through SETTLE and DRAW into PLAY.
    task automatic to_play();
        step();
        step();
        chk("draw_enable in DRAW", 32'(bus.draw_enable), 32'd1);
        bus.done_draw = 1'b1;
        step();
        bus.done_draw = 1'b0;
        chk("round_active in PLAY", 32'(bus.round_active), 32'd1);
    endtask

    // From LOST: confirm the state holds, then restart.
    task automatic restart(input logic [7:0] held_score);
        bus.player_key = 4'b0001;
        step();
        bus.player_key = 4'd0;
        chk("lose held", 32'(bus.lose), 32'd1);
        chk("score frozen", 32'(bus.score), 32'(held_score));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart score", 32'(bus.score), 32'd0);
        chk("restart lfsr_enable", 32'(bus.lfsr_enable), 32'd1);
        to_play();
    endtask

    initial begin
        vecs[0] = '{mask: 4'b0101, key: 4'b0100, win: 1'b1, score: 8'd1};
        vecs[1] = '{mask: 4'b1000, key: 4'b1000, win: 1'b1, score: 8'd2};
        vecs[2] = '{mask: 4'b0101, key: 4'b0010, win: 1'b0, score: 8'd2};
        vecs[3] = '{mask: 4'b0011, key: 4'b0011, win: 1'b0, score: 8'd0};
        vecs[4] = '{mask: 4'b1111, key: 4'b0001, win: 1'b1, score: 8'd1};
        vecs[5] = '{mask: 4'b0110, key: 4'b1001, win: 1'b0, score: 8'd1};
        vecs[6] = '{mask: 4'b0000, key: 4'b0001, win: 1'b0, score: 8'd0};

        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.answer_mask = 4'd0;
        bus.player_key  = 4'd0;
        bus.done_draw   = 1'b0;
        step();
        step();
        chk("reset show_start", 32'(bus.show_start), 32'd1);
        chk("reset lose", 32'(bus.lose), 32'd0);
        chk("reset lfsr_enable", 32'(bus.lfsr_enable), 32'd0);
        chk("reset draw_enable", 32'(bus.draw_enable), 32'd0);
        chk("reset round_active", 32'(bus.round_active), 32'd0);
        chk("reset time_left", 32'(bus.time_left), 32'd0);
        chk("reset score", 32'(bus.score), 32'd0);

        resetn = 1'b1;
        step();
        chk("idle show_start", 32'(bus.show_start), 32'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start lfsr_enable", 32'(bus.lfsr_enable), 32'd1);
        chk("start show_start", 32'(bus.show_start), 32'd0);
        step();
        chk("settle lfsr_enable", 32'(bus.lfsr_enable), 32'd0);
        chk("settle draw_enable", 32'(bus.draw_enable), 32'd0);
        step();
        chk("draw_enable 2 after lfsr", 32'(bus.draw_enable), 32'd1);
        bus.player_key = 4'b0001;
        step();
        bus.player_key = 4'd0;
        chk("key in DRAW ignored", 32'(bus.draw_enable), 32'd1);
        chk("no play during DRAW", 32'(bus.round_active), 32'd0);
        bus.done_draw = 1'b1;
        step();
        bus.done_draw = 1'b0;
        chk("play round_active", 32'(bus.round_active), 32'd1);
        chk("play draw_enable", 32'(bus.draw_enable), 32'd0);
        chk("play time_left", 32'(bus.time_left), 32'd9);
        $display("setup: start -> PLAY, time_left=%0d", bus.time_left);

        for (int i = 0; i < 7; i++) begin
            bus.answer_mask = vecs[i].mask;
            bus.player_key  = vecs[i].key;
            step();
            bus.player_key  = 4'd0;
            chk("vec lfsr_enable", 32'(bus.lfsr_enable), 32'(vecs[i].win));
            chk("vec lose", 32'(bus.lose), 32'(!vecs[i].win));
            chk("vec score", 32'(bus.score), 32'(vecs[i].score));
            $display("vec %0d: mask=%b key=%b lose=%0b score=%0d", i, vecs[i].mask, vecs[i].key,
                     bus.lose, bus.score);
            if (vecs[i].win) to_play();
            else restart(vecs[i].score);
        end

        // Timeout with a non-empty mask; a start pulse in PLAY is ignored.
        bus.answer_mask = 4'b0011;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start ignored in PLAY", 32'(bus.round_active), 32'd1);
        chk("no lfsr on start in PLAY", 32'(bus.lfsr_enable), 32'd0);
        for (int t = 0; t < 18; t++) step();
        chk("timer zero still PLAY", 32'(bus.round_active), 32'd1);
        chk("timer zero time_left", 32'(bus.time_left), 32'd0);
        step();
        chk("timeout lose", 32'(bus.lose), 32'd1);
        $display("timeout mask=0011: lose=%0b score=%0d", bus.lose, bus.score);
        restart(8'd0);

        // Timeout with an empty mask wins.
        bus.answer_mask = 4'b0000;
        for (int t = 0; t < 19; t++) step();
        step();
        chk("timeout mask0 lfsr_enable", 32'(bus.lfsr_enable), 32'd1);
        chk("timeout mask0 score", 32'(bus.score), 32'd1);
        $display("timeout mask=0000: score=%0d", bus.score);
        to_play();

        // Key on the expiry cycle wins over the timeout.
        bus.answer_mask = 4'b0011;
        for (int t = 0; t < 19; t++) step();
        bus.player_key = 4'b0010;
        step();
        bus.player_key = 4'd0;
        chk("key at expiry lfsr_enable", 32'(bus.lfsr_enable), 32'd1);
        chk("key at expiry score", 32'(bus.score), 32'd2);
        chk("sat score at 2", 32'(bus2.score), 32'd2);
        $display("key at expiry: score=%0d", bus.score);
        to_play();

        bus.answer_mask = 4'b0001;
        for (int w = 0; w < 3; w++) begin
            bus.player_key = 4'b0001;
            step();
            bus.player_key = 4'd0;
            chk("win run score", 32'(bus.score), 32'(3 + w));
            $display("win run %0d: score=%0d sat_score=%0d", w, bus.score, bus2.score);
            to_play();
        end
        chk("score 5 in PLAY", 32'(bus.score), 32'd5);
        chk("2-bit score saturates", 32'(bus2.score), 32'd3);

        // Asynchronous reset mid-PLAY.
        #2 resetn = 1'b0;
        #1;
        chk("async rst round_active", 32'(bus.round_active), 32'd0);
        chk("async rst show_start", 32'(bus.show_start), 32'd1);
        chk("async rst score", 32'(bus.score), 32'd0);
        chk("async rst time_left", 32'(bus.time_left), 32'd0);
        chk("async rst lose", 32'(bus.lose), 32'd0);
        $display("reset mid-PLAY: score=%0d show_start=%0b", bus.score, bus.show_start);

        // Asynchronous reset mid-DRAW drops the draw request.
        step();
        resetn = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("redraw draw_enable", 32'(bus.draw_enable), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async rst draw_enable", 32'(bus.draw_enable), 32'd0);
        chk("async rst draw show_start", 32'(bus.show_start), 32'd1);
        $display("reset mid-DRAW: draw_enable=%0b", bus.draw_enable);
        resetn = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
